dca_matrix_row_reader: RTL and testbench
========================================

DCA_MATRIX_ROW_READER -- requirements
Module: dca_matrix_row_reader

Interface
REQ-001 SHALL have parameter BW_AXI_DATA, default 32, AXI read-data width in bits (power of two, >= 32).
REQ-002 SHALL have parameter BW_ELEMENT, default 8, matrix element width in bits.
REQ-003 SHALL have parameter NUM_COL, default 4, elements per row; BW_ROW = NUM_COL*BW_ELEMENT <= BW_AXI_DATA.
REQ-004 SHALL have localparam MAX_BEATS = 2, beats a misaligned row can span.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rstnn  input  1  reset; asynchronous, active-low.
REQ-007 enable  input  1  stall when 0: no state, counter or buffer changes.
REQ-008 txn_valid  input  1  row-transaction descriptor valid.
REQ-009 txn_ready  output  1  descriptor accepted when txn_valid & txn_ready.
REQ-010 txn_reuse  input  1  row lies in the beat(s) already buffered; no R beats are consumed.
REQ-011 txn_last  input  1  last row of the matrix.
REQ-012 txn_alen  input  8  AXI burst length minus 1 for this row.
REQ-013 txn_bitaddr  input  log2(BW_AXI_DATA)  bit offset of the row inside the first beat, byte aligned.
REQ-014 txn_col_mask  input  NUM_COL  bit i = column i valid.
REQ-015 rvalid / rready / rlast  input / output / input  1 each  AXI R handshake.
REQ-016 rdata  input  BW_AXI_DATA  AXI read data.
REQ-017 row_valid / row_ready  output / input  1 each  aligned-row handshake.
REQ-018 row_data  output  BW_ROW  aligned row, column 0 in LSBs.
REQ-019 row_last  output  1  row_data is the last matrix row.
REQ-020 burst_error  output  1  sticky rlast-mismatch flag.
REQ-021 busy  output  1  high in any state other than IDLE.

Function
REQ-022 FSM states SHALL be IDLE, COLLECT, OUTPUT; transitions only when enable=1.
REQ-023 IDLE: txn_ready=1; on accept, latch descriptor; go to OUTPUT if txn_reuse, else clear beat counter and go to COLLECT.
REQ-024 COLLECT: rready=1; each rvalid&rready writes rdata to buffer slot beat_cnt and increments beat_cnt; on beat beat_cnt==alen go to OUTPUT.
REQ-025 On the final beat, if rlast=0, or if rlast=1 on any earlier beat, burst_error SHALL set and remain set until reset.
REQ-026 alen >= MAX_BEATS SHALL be treated as burst error; beats beyond MAX_BEATS-1 are consumed but discarded.
REQ-027 OUTPUT: row_valid=1; row_data = BW_ROW bits of {slot1,slot0} starting at bit bitaddr; on row_valid&row_ready go to IDLE.
REQ-028 row_data and row_last SHALL be stable while row_valid=1 and row_ready=0.
REQ-029 rready SHALL be 0 outside COLLECT; txn_ready SHALL be 0 outside IDLE.
REQ-030 Reuse transaction SHALL use buffer contents from the most recent non-reuse transaction unchanged.
REQ-031 Minimum latency: last R beat accepted at cycle N -> row_valid at N+1; reuse accept at N -> row_valid at N+1.
REQ-032 enable=0 while row_valid=1 SHALL hold row_valid, row_data stable; handshakes are not completed.

Reset
REQ-033 rstnn=0 SHALL immediately force IDLE, beat counter 0, buffer 0, burst_error 0, row_valid 0, rready 0, txn_ready 1 after release.
REQ-034 Reset mid-burst SHALL discard partial row; no row_valid produced for it.

Configuration
REQ-035 Macro DCA_ROW_READER_COL_MASK_EN: defined -> columns with txn_col_mask[i]=0 output as zero; undefined -> txn_col_mask ignored, raw extracted bits output.

Verification
REQ-036 bitaddr=0, alen=0, rdata=0x44332211, rlast=1 -> row_data=0x44332211, row_valid one cycle after beat, burst_error=0.
REQ-037 bitaddr=16, alen=1, beats 0x44332211,0x88776655 -> row_data=0x66554433.
REQ-038 after REQ-037, reuse txn bitaddr=8 -> no rready, row_data=0x55443322.
REQ-039 alen=1, rlast=1 on beat 0 -> burst_error=1, stays 1 through later transactions until rstnn=0.
REQ-040 col_mask=4'b0011, macro defined, data 0x44332211 -> 0x00002211; undefined -> 0x44332211.
REQ-041 row_ready held 0 for 5 cycles, then rstnn pulsed low mid-burst -> row_data stable while stalled; after reset IDLE, row_valid=0.

Source files
------------

// File: rtl/dca_matrix_row_reader.sv
// Collects one or two AXI R beats and extracts a byte-aligned matrix row from them.
// Optional column masking is enabled by defining DCA_ROW_READER_COL_MASK_EN.
module dca_matrix_row_reader #(
  parameter  int BW_AXI_DATA = 32,
  parameter  int BW_ELEMENT  = 8,
  parameter  int NUM_COL     = 4,
  localparam int BW_ROW      = NUM_COL * BW_ELEMENT,
  localparam int BW_ADDR     = $clog2(BW_AXI_DATA)
) (
  input  logic                   clk,
  input  logic                   rstnn,
  input  logic                   enable,
  input  logic                   txn_valid,
  output logic                   txn_ready,
  input  logic                   txn_reuse,
  input  logic                   txn_last,
  input  logic [7:0]             txn_alen,
  input  logic [BW_ADDR-1:0]     txn_bitaddr,
  input  logic [NUM_COL-1:0]     txn_col_mask,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic                   rlast,
  input  logic [BW_AXI_DATA-1:0] rdata,
  output logic                   row_valid,
  input  logic                   row_ready,
  output logic [BW_ROW-1:0]      row_data,
  output logic                   row_last,
  output logic                   burst_error,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  localparam int MAX_BEATS = 2;

  typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_OUTPUT} state_e;

  state_e                 state_q, state_d;
  logic [7:0]             beat_cnt_q, beat_cnt_d;
  logic [7:0]             alen_q, alen_d;
  logic [BW_ADDR-1:0]     bitaddr_q, bitaddr_d;
  logic                   last_q, last_d;
  logic [BW_AXI_DATA-1:0] slot0_q, slot0_d;
  logic [BW_AXI_DATA-1:0] slot1_q, slot1_d;
  logic                   err_q, err_d;
  logic                   txn_ready_q, txn_ready_d;
  logic                   rready_q, rready_d;
  logic                   row_valid_q, row_valid_d;
  logic [BW_ROW-1:0]      raw_row;
`ifdef DCA_ROW_READER_COL_MASK_EN
  logic [NUM_COL-1:0]     mask_q, mask_d;
`else
  logic                   unused_col_mask;
  assign unused_col_mask = ^txn_col_mask;
`endif

  // Handshakes: a transfer happens on a rising edge where valid & ready & enable.
  // txn_ready/rready are gated by enable so a stalled block never completes them.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    alen_d      = alen_q;
    bitaddr_d   = bitaddr_q;
    last_d      = last_q;
    slot0_d     = slot0_q;
    slot1_d     = slot1_q;
    err_d       = err_q;
    txn_ready_d = txn_ready_q;
    rready_d    = rready_q;
    row_valid_d = row_valid_q;
`ifdef DCA_ROW_READER_COL_MASK_EN
    mask_d      = mask_q;
`endif
    if (enable) begin
      case (state_q)
        ST_IDLE: begin
          if (txn_valid) begin
            alen_d      = txn_alen;
            bitaddr_d   = txn_bitaddr;
            last_d      = txn_last;
            txn_ready_d = 1'b0;
`ifdef DCA_ROW_READER_COL_MASK_EN
            mask_d      = txn_col_mask;
`endif
            if (txn_reuse) begin
              state_d     = ST_OUTPUT;
              row_valid_d = 1'b1;
            end else begin
              state_d    = ST_COLLECT;
              beat_cnt_d = 8'd0;
              rready_d   = 1'b1;
              if (txn_alen >= 8'(MAX_BEATS)) err_d = 1'b1;
            end
          end
        end
        ST_COLLECT: begin
          if (rvalid) begin
            // Beats past the buffer depth are drained from the bus but not stored.
            if (beat_cnt_q == 8'd0) slot0_d = rdata;
            else if (beat_cnt_q == 8'd1) slot1_d = rdata;
            beat_cnt_d = beat_cnt_q + 8'd1;
            if (beat_cnt_q == alen_q) begin
              if (!rlast) err_d = 1'b1;
              state_d     = ST_OUTPUT;
              rready_d    = 1'b0;
              row_valid_d = 1'b1;
            end else if (rlast) begin
              err_d = 1'b1;
            end
          end
        end
        ST_OUTPUT: begin
          if (row_ready) begin
            state_d     = ST_IDLE;
            row_valid_d = 1'b0;
            txn_ready_d = 1'b1;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          txn_ready_d = 1'b1;
          rready_d    = 1'b0;
          row_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= 8'd0;
      alen_q      <= 8'd0;
      bitaddr_q   <= '0;
      last_q      <= 1'b0;
      slot0_q     <= '0;
      slot1_q     <= '0;
      err_q       <= 1'b0;
      txn_ready_q <= 1'b1;
      rready_q    <= 1'b0;
      row_valid_q <= 1'b0;
`ifdef DCA_ROW_READER_COL_MASK_EN
      mask_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      alen_q      <= alen_d;
      bitaddr_q   <= bitaddr_d;
      last_q      <= last_d;
      slot0_q     <= slot0_d;
      slot1_q     <= slot1_d;
      err_q       <= err_d;
      txn_ready_q <= txn_ready_d;
      rready_q    <= rready_d;
      row_valid_q <= row_valid_d;
`ifdef DCA_ROW_READER_COL_MASK_EN
      mask_q      <= mask_d;
`endif
    end
  end

  // The buffer is frozen outside COLLECT, so the extracted row is stable while offered.
  assign raw_row = BW_ROW'({slot1_q, slot0_q} >> bitaddr_q);

`ifdef DCA_ROW_READER_COL_MASK_EN
  always_comb begin
    row_data = '0;
    for (int i = 0; i < NUM_COL; i++) begin
      if (mask_q[i]) row_data[i*BW_ELEMENT +: BW_ELEMENT] = raw_row[i*BW_ELEMENT +: BW_ELEMENT];
    end
  end
`else
  assign row_data = raw_row;
`endif

  assign txn_ready   = txn_ready_q & enable;
  assign rready      = rready_q & enable;
  assign row_valid   = row_valid_q;
  assign row_last    = last_q;
  assign burst_error = err_q;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_dca_matrix_row_reader.sv
// Directed bench for dca_matrix_row_reader: drivers push expected rows, a monitor
// pops and compares them whenever a row handshake completes.
module tb_dca_matrix_row_reader;

  localparam int W   = 32;
  localparam int ROW = 32;

  logic          clk = 1'b0;
  logic          rstnn;
  logic          enable;
  logic          txn_valid;
  logic          txn_ready;
  logic          txn_reuse;
  logic          txn_last;
  logic [7:0]    txn_alen;
  logic [4:0]    txn_bitaddr;
  logic [3:0]    txn_col_mask;
  logic          rvalid;
  logic          rready;
  logic          rlast;
  logic [W-1:0]  rdata;
  logic          row_valid;
  logic          row_ready;
  logic [ROW-1:0] row_data;
  logic          row_last;
  logic          burst_error;
  logic          busy;
  logic [1:0]    dbg_state;

  int checks   = 0;
  int failures = 0;

  // {row_last, row_data}
  logic [ROW:0] exp_q[$];

  dca_matrix_row_reader dut (
    .clk(clk), .rstnn(rstnn), .enable(enable),
    .txn_valid(txn_valid), .txn_ready(txn_ready), .txn_reuse(txn_reuse),
    .txn_last(txn_last), .txn_alen(txn_alen), .txn_bitaddr(txn_bitaddr),
    .txn_col_mask(txn_col_mask),
    .rvalid(rvalid), .rready(rready), .rlast(rlast), .rdata(rdata),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .row_last(row_last), .burst_error(burst_error), .busy(busy),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rstnn && enable && row_valid && row_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_row", {31'd0, row_last, row_data}, 64'hdead);
      end else begin
        logic [ROW:0] e;
        e = exp_q.pop_front();
        check("row_data", 64'(row_data), 64'(e[ROW-1:0]));
        check("row_last", 64'(row_last), 64'(e[ROW]));
      end
    end
  end

  // driver tasks
  task automatic send_txn(input logic reuse, input logic last, input logic [7:0] alen,
                          input logic [4:0] bitaddr, input logic [3:0] mask);
    int n;
    txn_valid = 1'b1; txn_reuse = reuse; txn_last = last;
    txn_alen = alen; txn_bitaddr = bitaddr; txn_col_mask = mask;
    @(negedge clk);
    n = 0;
    while (!txn_ready && n < 100) begin @(negedge clk); n++; end
    if (!txn_ready) check("txn_accept_timeout", 64'(txn_ready), 64'd1);
    @(posedge clk); #1;
    txn_valid = 1'b0;
  endtask

  task automatic send_beats(input int nb, input logic [W-1:0] d0, input logic [W-1:0] d1,
                            input logic [W-1:0] d2, input logic [2:0] last_pat);
    int n;
    logic [W-1:0] d;
    for (int b = 0; b < nb; b++) begin
      d = (b == 0) ? d0 : (b == 1) ? d1 : d2;
      rvalid = 1'b1; rdata = d; rlast = last_pat[b];
      @(negedge clk);
      n = 0;
      while (!rready && n < 100) begin @(negedge clk); n++; end
      if (!rready) check("rready_timeout", 64'(rready), 64'd1);
      @(posedge clk); #1;
    end
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic wait_rows_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    check("rows_drained", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rstnn = 1'b0; enable = 1'b1; txn_valid = 1'b0; txn_reuse = 1'b0; txn_last = 1'b0;
    txn_alen = 8'd0; txn_bitaddr = 5'd0; txn_col_mask = 4'hf;
    rvalid = 1'b0; rlast = 1'b0; rdata = '0; row_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstnn = 1'b1;
    @(negedge clk);
    check("rst_txn_ready", 64'(txn_ready), 64'd1);
    check("rst_rready", 64'(rready), 64'd0);
    check("rst_row_valid", 64'(row_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_burst_error", 64'(burst_error), 64'd0);
    @(posedge clk); #1;

    // single aligned beat
    exp_q.push_back({1'b0, 32'h44332211});
    send_txn(1'b0, 1'b0, 8'd0, 5'd0, 4'hf);
    send_beats(1, 32'h44332211, 32'h0, 32'h0, 3'b001);
    check("latency_single_beat", 64'(row_valid), 64'd1);
    check("no_err_single_beat", 64'(burst_error), 64'd0);
    wait_rows_done();

    // row spanning two beats
    exp_q.push_back({1'b0, 32'h66554433});
    send_txn(1'b0, 1'b0, 8'd1, 5'd16, 4'hf);
    send_beats(2, 32'h44332211, 32'h88776655, 32'h0, 3'b010);
    check("latency_two_beats", 64'(row_valid), 64'd1);
    wait_rows_done();

    // reuse of buffered beats
    exp_q.push_back({1'b0, 32'h55443322});
    send_txn(1'b1, 1'b0, 8'd0, 5'd8, 4'hf);
    check("latency_reuse", 64'(row_valid), 64'd1);
    check("reuse_no_rready", 64'(rready), 64'd0);
    wait_rows_done();

    // last matrix row at offset 24
    exp_q.push_back({1'b1, 32'h77665544});
    send_txn(1'b0, 1'b1, 8'd1, 5'd24, 4'hf);
    send_beats(2, 32'h44332211, 32'h88776655, 32'h0, 3'b010);
    wait_rows_done();

    // column mask
`ifdef DCA_ROW_READER_COL_MASK_EN
    exp_q.push_back({1'b0, 32'h00002211});
`else
    exp_q.push_back({1'b0, 32'h44332211});
`endif
    send_txn(1'b0, 1'b0, 8'd0, 5'd0, 4'b0011);
    send_beats(1, 32'h44332211, 32'h0, 32'h0, 3'b001);
    wait_rows_done();

    // backpressure then enable stall
    row_ready = 1'b0;
    exp_q.push_back({1'b0, 32'hddccbbaa});
    send_txn(1'b0, 1'b0, 8'd0, 5'd0, 4'hf);
    send_beats(1, 32'hddccbbaa, 32'h0, 32'h0, 3'b001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_row_data", 64'(row_data), 64'hddccbbaa);
    end
    @(posedge clk); #1;
    enable = 1'b0; row_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("enable_hold_valid", 64'(row_valid), 64'd1);
    end
    @(posedge clk); #1;
    enable = 1'b1;
    wait_rows_done();

    // rlast on an early beat
    exp_q.push_back({1'b0, 32'h11111111});
    send_txn(1'b0, 1'b0, 8'd1, 5'd0, 4'hf);
    send_beats(2, 32'h11111111, 32'h22222222, 32'h0, 3'b011);
    check("early_rlast_err", 64'(burst_error), 64'd1);
    wait_rows_done();
    exp_q.push_back({1'b0, 32'h12345678});
    send_txn(1'b0, 1'b0, 8'd0, 5'd0, 4'hf);
    send_beats(1, 32'h12345678, 32'h0, 32'h0, 3'b001);
    wait_rows_done();
    check("err_sticky", 64'(burst_error), 64'd1);

    // reset mid-burst
    send_txn(1'b0, 1'b0, 8'd1, 5'd0, 4'hf);
    send_beats(1, 32'hcafef00d, 32'h0, 32'h0, 3'b000);
    rvalid = 1'b1; rdata = 32'hbeefbeef;
    #1 rstnn = 1'b0;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_rready", 64'(rready), 64'd0);
    rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstnn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_row_valid", 64'(row_valid), 64'd0);
    end
    check("post_rst_txn_ready", 64'(txn_ready), 64'd1);
    check("post_rst_err_clear", 64'(burst_error), 64'd0);
    @(posedge clk); #1;

    // buffer cleared by reset
    exp_q.push_back({1'b0, 32'h00000000});
    send_txn(1'b1, 1'b0, 8'd0, 5'd0, 4'hf);
    wait_rows_done();

    // burst longer than the buffer: extra beat dropped, error flagged
    exp_q.push_back({1'b0, 32'h06050403});
    send_txn(1'b0, 1'b0, 8'd2, 5'd16, 4'hf);
    send_beats(3, 32'h04030201, 32'h08070605, 32'hffffffff, 3'b100);
    wait_rows_done();
    check("long_burst_err", 64'(burst_error), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
